// File: rtl/weight_pattern_generator_pkg.sv
// rtl/weight_pattern_generator_pkg.sv - shared widths, state type and pattern helpers
package weight_pattern_generator_pkg;

    localparam int PATTERN_W = 7;
    localparam int COUNT_W   = 3;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PATTERN_W:0] ONE_EXT = 1;

    // Lowest vector of weight k: k ones packed at the bottom.
    function automatic logic [PATTERN_W-1:0] first_pattern(input logic [COUNT_W-1:0] k);
        logic [PATTERN_W:0] ones;
        ones = (ONE_EXT << k) - ONE_EXT;
        return ones[PATTERN_W-1:0];
    endfunction

    function automatic logic [PATTERN_W-1:0] last_pattern(input logic [COUNT_W-1:0] k);
        return first_pattern(k) << (COUNT_W'(PATTERN_W) - k);
    endfunction

endpackage

// File: rtl/weight_pattern_generator_if.sv
// rtl/weight_pattern_generator_if.sv - request/stream bundle between generator and consumer
interface weight_pattern_generator_if;
    import weight_pattern_generator_pkg::*;

    logic                 start;
    logic [COUNT_W-1:0]   weight;
    logic                 ready;
    logic [PATTERN_W-1:0] pattern;
    logic                 valid;
    logic [5:0]           index;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        input  start, weight, ready,
        output pattern, valid, index, busy, done, err
    );

    modport slave (
        output start, weight, ready,
        input  pattern, valid, index, busy, done, err
    );
endinterface

// File: rtl/ones_count.sv
// rtl/ones_count.sv - combinational 7-input popcount adder tree
module ones_count (
    input  logic [6:0] bits,
    output logic [2:0] count
);
    logic [1:0] sum_lo;
    logic [1:0] sum_hi;

    assign sum_lo = {1'b0, bits[0]} + {1'b0, bits[1]} + {1'b0, bits[2]};
    assign sum_hi = {1'b0, bits[3]} + {1'b0, bits[4]} + {1'b0, bits[5]};
    assign count  = {1'b0, sum_lo} + {1'b0, sum_hi} + {2'b00, bits[6]};
endmodule

// File: rtl/weight_pattern_generator.sv
// rtl/weight_pattern_generator.sv - enumerates all 7-bit vectors of a given weight; WEIGHT_PATTERN_SELF_CHECK_EN adds popcount checker
module weight_pattern_generator
    import weight_pattern_generator_pkg::*;
#(
    parameter int N = PATTERN_W,
    parameter int W = COUNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    weight_pattern_generator_if.master    bus
);

    state_t         state;
    logic [W-1:0]   k;
    logic [N-1:0]   x;
    logic [N-1:0]   c;
    logic [N:0]     r;
    logic [N-1:0]   nxt;
    logic [2:0]     tz;
    logic [3:0]     shamt;
    logic           is_last;
    logic           unused_carry;

    assign x            = bus.pattern;
    assign c            = x & (-x);
    assign r            = {1'b0, x} + {1'b0, c};
    assign unused_carry = r[N];
    assign shamt        = {1'b0, tz} + 4'd2;
    assign nxt          = r[N-1:0] | ((x ^ r[N-1:0]) >> shamt);
    // Last-pattern test comes first, so tz of an all-zero vector never matters.
    assign is_last      = (bus.pattern == last_pattern(k));

    always_comb begin
        tz = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) tz = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            bus.pattern <= '0;
            bus.valid   <= 1'b0;
            bus.index   <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k           <= bus.weight;
                        bus.pattern <= first_pattern(bus.weight);
                        bus.index   <= '0;
                        bus.valid   <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (bus.valid && bus.ready) begin
                        if (is_last) begin
                            bus.valid <= 1'b0;
                            bus.busy  <= 1'b0;
                            bus.done  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            bus.pattern <= nxt;
                            bus.index   <= bus.index + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_PATTERN_SELF_CHECK_EN
    logic [W-1:0] pop;

    ones_count u_ones_count (
        .bits  (bus.pattern),
        .count (pop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err <= 1'b0;
        end else if (bus.valid && (pop != k)) begin
            bus.err <= 1'b1;
        end
    end
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_pattern_generator.sv
// tb/tb_weight_pattern_generator.sv - directed sweeps against an ascending-enumeration model
module tb_weight_pattern_generator;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    weight_pattern_generator_if bus ();

    weight_pattern_generator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int k, input bit rnd, input int inject_at, input int abort_at);
        int  exp_q[$];
        int  acc;
        int  cyc;
        bit  accepted;
        for (int v = 0; v < 128; v++) begin
            if ($countones(v[6:0]) == k) exp_q.push_back(v);
        end
        bus.start  = 1'b1;
        bus.weight = 3'(k);
        tick();
        bus.start = 1'b0;
        check("first_valid", bus.valid, 1);
        check("first_busy", bus.busy, 1);
        check("done_clear", bus.done, 0);
        acc = 0;
        cyc = 0;
        while (acc < exp_q.size() && cyc < 400) begin
            bus.ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (acc == inject_at) begin
                bus.start  = 1'b1;
                bus.weight = 3'd5;
            end
            check("pattern", bus.pattern, exp_q[acc]);
            check("index", bus.index, acc);
            check("valid", bus.valid, 1);
            if (acc == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_pattern", bus.pattern, 0);
                check("rst_valid", bus.valid, 0);
                check("rst_index", bus.index, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                @(posedge clk);
                #1;
                rst       = 1'b0;
                bus.ready = 1'b0;
                tick();
                check("post_rst_done", bus.done, 0);
                check("post_rst_valid", bus.valid, 0);
                check("post_rst_busy", bus.busy, 0);
                return;
            end
            accepted = bus.ready;
            tick();
            bus.start = 1'b0;
            if (accepted) acc++;
            cyc++;
        end
        check("sweep_len", acc, exp_q.size());
        check("end_valid", bus.valid, 0);
        check("end_busy", bus.busy, 0);
        check("end_done", bus.done, 1);
        check("err", bus.err, 0);
        bus.ready = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.weight = 3'd0;
        bus.ready  = 1'b0;
        repeat (2) tick();
        check("reset_pattern", bus.pattern, 0);
        check("reset_valid", bus.valid, 0);
        check("reset_index", bus.index, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_err", bus.err, 0);
        rst = 1'b0;
        tick();
        check("idle_valid", bus.valid, 0);

        sweep(0, 1'b0, -1, -1);
        tick();
        check("k0_done_drop", bus.done, 0);
        sweep(1, 1'b0, -1, -1);
        tick();
        check("k1_done_drop", bus.done, 0);
        sweep(3, 1'b0, -1, -1);
        tick();
        sweep(4, 1'b1, -1, -1);
        tick();
        sweep(2, 1'b0, 10, -1);
        sweep(5, 1'b0, -1, -1);
        tick();
        check("k5_done_drop", bus.done, 0);
        sweep(3, 1'b0, -1, 12);
        sweep(7, 1'b0, -1, -1);
        tick();
        check("k7_done_drop", bus.done, 0);
        check("final_err", bus.err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
